uart_frame_tx_sched: RTL and testbench

//  Shares one single-byte UART transmitter between two requesters. Each requester offers a 46-bit word.
//  The block arbitrates round-robin, zero-pads the word to 48 bits and sends it as 6 bytes, MSB byte first.

---
 rtl/uart_frame_tx_sched_if.sv | 29 ++
 rtl/uart_frame_tx_sched.sv | 136 +++++++++++++
 tb/tb_uart_frame_tx_sched.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_tx_sched_if.sv
// Requester and byte-transmitter signals of the two-requester UART frame scheduler.
// master: producers plus byte transmitter side; slave: the scheduler.
interface uart_frame_tx_sched_if #(
    parameter int DATA_W = 46
);
    logic              req0;
    logic              req1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              ack0;
    logic              ack1;
    logic              done0;
    logic              done1;
    logic              busy;
    logic              err_timeout;
    logic              byte_start;
    logic [7:0]        byte_data;
    logic              byte_tx_done;

    modport master (
        output req0, req1, data0, data1, byte_tx_done,
        input  ack0, ack1, done0, done1, busy, err_timeout, byte_start, byte_data
    );

    modport slave (
        input  req0, req1, data0, data1, byte_tx_done,
        output ack0, ack1, done0, done1, busy, err_timeout, byte_start, byte_data
    );
endinterface

// File: rtl/uart_frame_tx_sched.sv
// Round-robin scheduler sending a zero-padded DATA_W word as NBYTES bytes, MSB first (UART_FRAME_CKSUM_EN appends an XOR byte).
// Latency: req -> ack +1 cycle, first byte_start +2, last byte_tx_done -> done +1.
// Backpressure: one byte in flight; waits on byte_tx_done with a watchdog abort after TIMEOUT_CYC cycles.
module uart_frame_tx_sched #(
    parameter int DATA_W      = 46,
    parameter int NBYTES      = 6,
    parameter int GAP_CYC     = 0,
    parameter int TIMEOUT_CYC = 2**20
) (
    input  logic                  clk,
    input  logic                  reset_n,
    uart_frame_tx_sched_if.slave  bus
);
    localparam int SR_W = NBYTES * 8;
`ifdef UART_FRAME_CKSUM_EN
    localparam int NFRAME = NBYTES + 1;
`else
    localparam int NFRAME = NBYTES;
`endif
    localparam int IDX_W = (NFRAME > 1) ? $clog2(NFRAME) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFRAME - 1);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYC - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    logic [2:0]       state_q, state_d;
    logic             grant_q;
    logic             last_grant_q;
    logic [IDX_W-1:0] idx_q;
    logic [SR_W-1:0]  shift_q;
    logic [19:0]      wdog_q;
    logic [GAP_W-1:0] gap_q;
    logic             err_q;
    logic             win;
    logic             wd_expire;
    logic             is_last;

    // Both requesting: the one not served last time wins.
    assign win       = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
    assign wd_expire = (wdog_q == WD_LAST);
    assign is_last   = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.req0 || bus.req1) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.byte_tx_done) begin
                    if (is_last)          state_d = ST_DONE;
                    else if (GAP_CYC > 0) state_d = ST_GAP;
                    else                  state_d = ST_SEND;
                end else if (wd_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP:  if (gap_q == GAP_LAST) state_d = ST_SEND;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef UART_FRAME_CKSUM_EN
    localparam logic [IDX_W-1:0] CK_IDX = IDX_W'(NBYTES);
    logic [7:0] cksum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cksum_q <= 8'h00;
        end else if (state_q == ST_LOAD) begin
            cksum_q <= 8'h00;
        end else if (state_q == ST_WAIT && bus.byte_tx_done && !is_last) begin
            cksum_q <= cksum_q ^ shift_q[SR_W-1 -: 8];
        end
    end

    assign bus.byte_data = (idx_q == CK_IDX) ? cksum_q : shift_q[SR_W-1 -: 8];
`else
    assign bus.byte_data = shift_q[SR_W-1 -: 8];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            idx_q        <= '0;
            shift_q      <= '0;
            wdog_q       <= '0;
            gap_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == ST_WAIT) && !bus.byte_tx_done && wd_expire;
            case (state_q)
                ST_IDLE: grant_q <= win;
                ST_LOAD: begin
                    shift_q      <= SR_W'(grant_q ? bus.data1 : bus.data0);
                    idx_q        <= '0;
                    last_grant_q <= grant_q;
                end
                ST_SEND: wdog_q <= '0;
                ST_WAIT: begin
                    // Shift only on leaving WAIT so byte_data holds while the byte is on the wire.
                    if (bus.byte_tx_done) begin
                        if (!is_last) begin
                            idx_q   <= idx_q + IDX_W'(1);
                            shift_q <= shift_q << 8;
                            gap_q   <= '0;
                        end
                    end else begin
                        wdog_q <= wdog_q + 20'd1;
                    end
                end
                ST_GAP:  gap_q <= gap_q + GAP_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.ack0        = (state_q == ST_LOAD) && !grant_q;
    assign bus.ack1        = (state_q == ST_LOAD) &&  grant_q;
    assign bus.done0       = (state_q == ST_DONE) && !grant_q;
    assign bus.done1       = (state_q == ST_DONE) &&  grant_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.err_timeout = err_q;
    assign bus.byte_start  = (state_q == ST_SEND);
endmodule

// File: tb/tb_uart_frame_tx_sched.sv
// Bench for uart_frame_tx_sched: instance A (no gap) and instance B (GAP_CYC=5), both TIMEOUT_CYC=100.
`timescale 1ns/1ps
module tb_uart_frame_tx_sched;
    localparam int DW = 46;
    localparam int TO = 100;
`ifdef UART_FRAME_CKSUM_EN
    localparam int NF = 7;
`else
    localparam int NF = 6;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]    req0_d = '0, req1_d = '0, btd_d = '0, spur_d = '0;
    logic [DW-1:0] data0_d [2];
    logic [DW-1:0] data1_d [2];

    uart_frame_tx_sched_if #(.DATA_W(DW)) ifa ();
    uart_frame_tx_sched_if #(.DATA_W(DW)) ifb ();

    assign ifa.req0 = req0_d[0];
    assign ifa.req1 = req1_d[0];
    assign ifa.data0 = data0_d[0];
    assign ifa.data1 = data1_d[0];
    assign ifa.byte_tx_done = btd_d[0] | spur_d[0];
    assign ifb.req0 = req0_d[1];
    assign ifb.req1 = req1_d[1];
    assign ifb.data0 = data0_d[1];
    assign ifb.data1 = data1_d[1];
    assign ifb.byte_tx_done = btd_d[1] | spur_d[1];

    uart_frame_tx_sched #(.DATA_W(DW), .NBYTES(6), .GAP_CYC(0), .TIMEOUT_CYC(TO)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.slave));
    uart_frame_tx_sched #(.DATA_W(DW), .NBYTES(6), .GAP_CYC(5), .TIMEOUT_CYC(TO)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.slave));

    logic [1:0]  ack0_w, ack1_w, done0_w, done1_w, busy_w, err_w, start_w;
    logic [7:0]  bdata_w [2];
    logic [14:0] outs_w [2];
    assign ack0_w  = {ifb.ack0, ifa.ack0};
    assign ack1_w  = {ifb.ack1, ifa.ack1};
    assign done0_w = {ifb.done0, ifa.done0};
    assign done1_w = {ifb.done1, ifa.done1};
    assign busy_w  = {ifb.busy, ifa.busy};
    assign err_w   = {ifb.err_timeout, ifa.err_timeout};
    assign start_w = {ifb.byte_start, ifa.byte_start};
    assign bdata_w[0] = ifa.byte_data;
    assign bdata_w[1] = ifb.byte_data;
    assign outs_w[0] = {ifa.ack0, ifa.ack1, ifa.done0, ifa.done1, ifa.busy, ifa.err_timeout, ifa.byte_start, ifa.byte_data};
    assign outs_w[1] = {ifb.ack0, ifb.ack1, ifb.done0, ifb.done1, ifb.busy, ifb.err_timeout, ifb.byte_start, ifb.byte_data};

    // Byte transmitter model: answers each byte_start with a done pulse resp_dly cycles later, up to resp_lim answers.
    int resp_dly [2] = '{10, 10};
    int resp_lim [2] = '{0, 0};
    int answered [2] = '{0, 0};
    int pend     [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int done_cyc [2] = '{0, 0};
    always begin
        @(posedge clk);
        #2;
        for (int g = 0; g < 2; g++) begin
            btd_d[g] = 1'b0;
            if (!reset_n) begin
                pend[g] = 0;
            end else begin
                if (pend[g] > 0) begin
                    pend[g]--;
                    if (pend[g] == 0) begin
                        btd_d[g] = 1'b1;
                        done_cnt[g]++;
                        done_cyc[g] = cyc;
                    end
                end
                if (start_w[g] && answered[g] < resp_lim[g]) begin
                    pend[g] = resp_dly[g];
                    answered[g]++;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;
    bit lg_m [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int gap_of(input int d);
        return (d == 1) ? 5 : 0;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // Frame byte i: 48-bit zero-padded word split MSB first; byte 6 is the XOR of the six.
    function automatic logic [7:0] exp_byte(input logic [DW-1:0] dat, input int i);
        logic [47:0] w;
        logic [7:0]  x;
        w = {2'b00, dat};
        if (i < 6) return w[47 - 8*i -: 8];
        x = 8'h00;
        for (int k = 0; k < 6; k++) x = x ^ w[47 - 8*k -: 8];
        return x;
    endfunction

    task automatic do_frame(input int d, input int exp_lat, input bit drop, input int n_ans);
        int w, s, nd;
        bit who, exp_who, quiet;
        logic [DW-1:0] dat;
        exp_who = (req0_d[d] && req1_d[d]) ? ~lg_m[d] : req1_d[d];
        w = 0;
        do begin step(); w++; end while (!(ack0_w[d] || ack1_w[d]) && w < 20);
        chk("ack_seen", ack0_w[d] || ack1_w[d], 1);
        chk("ack_latency", w, exp_lat);
        who = ack1_w[d];
        chk("grant", who, exp_who);
        lg_m[d] = who;
        dat = who ? data1_d[d] : data0_d[d];
        if (drop) begin
            if (who) req1_d[d] = 1'b0; else req0_d[d] = 1'b0;
        end
        resp_lim[d] = answered[d] + n_ans;
        for (int i = 0; i < NF; i++) begin
            w = 0;
            while (!start_w[d] && w < 400) begin step(); w++; end
            chk("byte_start_seen", start_w[d], 1);
            if (i == 0) begin
                chk("first_start_latency", w, 1);
                if (!drop) begin
                    if (who) data1_d[d] = rnd_data(); else data0_d[d] = rnd_data();
                end
            end else begin
                chk("start_after_done", cyc - done_cyc[d], gap_of(d) + 1);
            end
            chk($sformatf("byte%0d", i), bdata_w[d], exp_byte(dat, i));
            chk("busy_in_frame", busy_w[d], 1);
            if (i >= n_ans) begin
                s = cyc;
                w = 0;
                while (!err_w[d] && w < TO + 50) begin step(); w++; end
                chk("err_timeout_seen", err_w[d], 1);
                chk("err_timeout_delay", cyc - s, TO + 1);
                chk("busy_after_timeout", busy_w[d], 0);
                quiet = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    step();
                    if (done0_w[d] || done1_w[d] || err_w[d] || start_w[d]) quiet = 1'b0;
                end
                chk("quiet_after_timeout", quiet, 1);
                return;
            end
            nd = done_cnt[d];
            quiet = 1'b1;
            w = 0;
            while (w < 400) begin
                step();
                w++;
                if (done_cnt[d] != nd) break;
                if (bdata_w[d] !== exp_byte(dat, i) || start_w[d] || done0_w[d] || done1_w[d] ||
                    err_w[d] || !busy_w[d]) quiet = 1'b0;
            end
            chk("wait_hold", quiet, 1);
        end
        chk("done_own", who ? done1_w[d] : done0_w[d], 1);
        chk("done_other", who ? done0_w[d] : done1_w[d], 0);
        chk("done_latency", cyc - done_cyc[d], 1);
        chk("no_err_at_done", err_w[d], 0);
    endtask

    initial begin
        int w, r;
        bit quiet;
        for (int d = 0; d < 2; d++) begin
            data0_d[d] = '0;
            data1_d[d] = '0;
            lg_m[d] = 1'b1;
        end
        repeat (3) step();
        chk("reset_outs_a", outs_w[0], 0);
        chk("reset_outs_b", outs_w[1], 0);
        reset_n = 1'b1;
        step();
        chk("idle_outs_a", outs_w[0], 0);

        // Tie from reset, requests held: frames alternate 0,1,0,1.
        data0_d[0] = rnd_data();
        data1_d[0] = rnd_data();
        req0_d[0] = 1'b1;
        req1_d[0] = 1'b1;
        resp_dly[0] = 4;
        do_frame(0, 1, 1'b0, NF);
        for (int k = 0; k < 3; k++) do_frame(0, 2, 1'b0, NF);
        req0_d[0] = 1'b0;
        req1_d[0] = 1'b0;
        repeat (4) step();
        chk("idle_after_tie", busy_w[0], 0);

        // Directed single frame.
        data0_d[0] = 46'h0123_4567_89AB;
        req0_d[0] = 1'b1;
        resp_dly[0] = 10;
        do_frame(0, 1, 1'b1, NF);
        repeat (3) step();

        // Random request patterns, payloads and transmitter delays.
        for (int it = 0; it < 8; it++) begin
            r = $urandom_range(1, 3);
            if (r[0] && !req0_d[0]) begin data0_d[0] = rnd_data(); req0_d[0] = 1'b1; end
            if (r[1] && !req1_d[0]) begin data1_d[0] = rnd_data(); req1_d[0] = 1'b1; end
            resp_dly[0] = $urandom_range(1, 12);
            do_frame(0, (it == 0) ? 1 : 2, 1'b1, NF);
        end
        while (req0_d[0] || req1_d[0]) do_frame(0, 2, 1'b1, NF);
        repeat (3) step();

        // Inter-byte gap on instance B.
        data0_d[1] = rnd_data();
        req0_d[1] = 1'b1;
        resp_dly[1] = $urandom_range(3, 9);
        do_frame(1, 1, 1'b1, NF);
        data1_d[1] = rnd_data();
        req1_d[1] = 1'b1;
        do_frame(1, 2, 1'b1, NF);
        repeat (3) step();

        // Watchdog: third byte never completes, then a full frame recovers.
        data1_d[0] = rnd_data();
        req1_d[0] = 1'b1;
        resp_dly[0] = 10;
        do_frame(0, 1, 1'b1, 2);
        data0_d[0] = rnd_data();
        req0_d[0] = 1'b1;
        do_frame(0, 1, 1'b1, NF);

        // byte_tx_done on the same cycle the watchdog expires counts as done.
        data1_d[0] = rnd_data();
        req1_d[0] = 1'b1;
        resp_dly[0] = TO;
        do_frame(0, 2, 1'b1, NF);
        repeat (2) step();

        // Reset in the middle of WAIT, then a spurious byte_tx_done while idle.
        data0_d[0] = rnd_data();
        req0_d[0] = 1'b1;
        resp_dly[0] = 50;
        resp_lim[0] = answered[0] + NF;
        w = 0;
        while (!start_w[0] && w < 20) begin step(); w++; end
        chk("pre_reset_start", start_w[0], 1);
        repeat (5) step();
        reset_n = 1'b0;
        req0_d[0] = 1'b0;
        lg_m[0] = 1'b1;
        lg_m[1] = 1'b1;
        step();
        chk("mid_reset_outs", outs_w[0], 0);
        reset_n = 1'b1;
        step();
        spur_d[0] = 1'b1;
        step();
        spur_d[0] = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (outs_w[0] !== 15'd0) quiet = 1'b0;
        end
        chk("idle_after_spurious_done", quiet, 1);

        // After reset requester 0 wins a tie again.
        data0_d[0] = rnd_data();
        data1_d[0] = rnd_data();
        req0_d[0] = 1'b1;
        req1_d[0] = 1'b1;
        resp_dly[0] = 3;
        do_frame(0, 1, 1'b1, NF);
        do_frame(0, 2, 1'b1, NF);
        repeat (3) step();
        chk("final_idle", busy_w[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
